// File: rtl/pipe_pkg.sv
// Shared pipeline constants: timing-field width and encodings, MDU latencies, $zero.
package pipe_pkg;
  localparam int TW = 3;

  // Tuse/Tnew encodings: 0 = now / result already available, larger = cycles away
  localparam logic [TW-1:0] T_NOW = 3'd0;
  localparam logic [TW-1:0] T_ONE = 3'd1;
  localparam logic [TW-1:0] T_TWO = 3'd2;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/hazard_match.sv
// One source operand checked against every producer stage: stall bit and forward select.
module hazard_match #(
  parameter int NPROD = 2,
  parameter int TW    = pipe_pkg::TW,
  parameter int SEL_W = $clog2(NPROD + 1)
) (
  input  logic [4:0]          d_reg,
  input  logic [TW-1:0]       d_tuse,
  input  logic [5*NPROD-1:0]  p_dst,
  input  logic [TW*NPROD-1:0] p_tnew,
  output logic                hit_stall,
  output logic [SEL_W-1:0]    fwd_sel
);
  import pipe_pkg::*;

  logic fwd_found;

  // Scan nearest stage first so the newest ready value is the one forwarded.
  always_comb begin
    hit_stall = 1'b0;
    fwd_sel   = '0;
    fwd_found = 1'b0;
    for (int k = 0; k < NPROD; k++) begin
      if ((p_dst[5*k +: 5] == d_reg) && (d_reg != REG_ZERO)) begin
        if (d_tuse < p_tnew[TW*k +: TW]) hit_stall = 1'b1;
        if ((p_tnew[TW*k +: TW] == '0) && !fwd_found) begin
          fwd_sel   = SEL_W'(k + 1);
          fwd_found = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/hazard_ctrl_mdu.sv
// Stall/forward controller: operand hazards, MDU busy tracking, saturating stall counter.
module hazard_ctrl_mdu #(
  parameter int NPROD    = 2,
  parameter int TW       = pipe_pkg::TW,
  parameter int MULT_CYC = pipe_pkg::MULT_CYC,
  parameter int DIV_CYC  = pipe_pkg::DIV_CYC,
  parameter int CNT_W    = 32,
  parameter int SEL_W    = $clog2(NPROD + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4:0]          d_rs,
  input  logic [4:0]          d_rt,
  input  logic [TW-1:0]       d_rs_tuse,
  input  logic [TW-1:0]       d_rt_tuse,
  input  logic                d_mdu_use,
  input  logic [5*NPROD-1:0]  p_dst,
  input  logic [TW*NPROD-1:0] p_tnew,
  input  logic                e_mdu_start,
  input  logic                e_mdu_div,
  output logic                stall,
  output logic                e_bubble,
  output logic [SEL_W-1:0]    fwd_rs_sel,
  output logic [SEL_W-1:0]    fwd_rt_sel,
  output logic                mdu_busy,
  output logic [CNT_W-1:0]    stall_cnt
);
  import pipe_pkg::*;

  localparam int BUSY_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int BUSY_W   = $clog2(BUSY_MAX + 1);

  logic              stall_rs;
  logic              stall_rt;
  logic              stall_mdu;
  logic [BUSY_W-1:0] busy_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  hazard_match #(.NPROD(NPROD), .TW(TW), .SEL_W(SEL_W)) u_match_rs (
    .d_reg(d_rs), .d_tuse(d_rs_tuse), .p_dst(p_dst), .p_tnew(p_tnew),
    .hit_stall(stall_rs), .fwd_sel(fwd_rs_sel)
  );

  hazard_match #(.NPROD(NPROD), .TW(TW), .SEL_W(SEL_W)) u_match_rt (
    .d_reg(d_rt), .d_tuse(d_rt_tuse), .p_dst(p_dst), .p_tnew(p_tnew),
    .hit_stall(stall_rt), .fwd_sel(fwd_rt_sel)
  );

  // Combine operand and MDU hazards; a start in E already blocks an MDU user in D.
  always_comb begin
    mdu_busy  = (busy_cnt != '0);
    stall_mdu = d_mdu_use && (e_mdu_start || mdu_busy);
    stall     = stall_rs || stall_rt || stall_mdu;
    e_bubble  = stall;
  end

  // MDU busy countdown: a start (even while busy) reloads, otherwise count down to zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_cnt <= '0;
    end else if (e_mdu_start) begin
      busy_cnt <= e_mdu_div ? BUSY_W'(DIV_CYC) : BUSY_W'(MULT_CYC);
    end else if (busy_cnt != '0) begin
      busy_cnt <= busy_cnt - BUSY_W'(1);
    end
  end

  // Stalled-cycle statistic, held at all-ones once full.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end
endmodule

// File: tb/tb_hazard_ctrl_mdu.sv
// Directed plus randomized check of hazard_ctrl_mdu against a cycle-level behavioural model.
module tb_hazard_ctrl_mdu;
  localparam int NPROD = 2;
  localparam int TW    = 3;
  localparam int SEL_W = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [4:0]         d_rs, d_rt;
  logic [TW-1:0]      d_rs_tuse, d_rt_tuse;
  logic               d_mdu_use;
  logic [4:0]         td [NPROD];
  logic [TW-1:0]      tn [NPROD];
  logic [5*NPROD-1:0] p_dst;
  logic [TW*NPROD-1:0] p_tnew;
  logic               e_mdu_start, e_mdu_div;

  logic               stall, e_bubble, mdu_busy;
  logic [SEL_W-1:0]   fwd_rs_sel, fwd_rt_sel;
  logic [31:0]        stall_cnt;
  logic               stall4, e_bubble4, mdu_busy4;
  logic [SEL_W-1:0]   fwd_rs_sel4, fwd_rt_sel4;
  logic [3:0]         stall_cnt4;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int busy_until = 0;
  longint m_cnt32 = 0;
  int m_cnt4 = 0;

  always #5 clk = ~clk;

  assign p_dst  = {td[1], td[0]};
  assign p_tnew = {tn[1], tn[0]};

  hazard_ctrl_mdu #(.NPROD(NPROD), .TW(TW), .MULT_CYC(5), .DIV_CYC(10), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt), .d_rs_tuse(d_rs_tuse),
    .d_rt_tuse(d_rt_tuse), .d_mdu_use(d_mdu_use), .p_dst(p_dst), .p_tnew(p_tnew),
    .e_mdu_start(e_mdu_start), .e_mdu_div(e_mdu_div), .stall(stall), .e_bubble(e_bubble),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
  );

  hazard_ctrl_mdu #(.NPROD(NPROD), .TW(TW), .MULT_CYC(5), .DIV_CYC(10), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .d_rs(d_rs), .d_rt(d_rt), .d_rs_tuse(d_rs_tuse),
    .d_rt_tuse(d_rt_tuse), .d_mdu_use(d_mdu_use), .p_dst(p_dst), .p_tnew(p_tnew),
    .e_mdu_start(e_mdu_start), .e_mdu_div(e_mdu_div), .stall(stall4), .e_bubble(e_bubble4),
    .fwd_rs_sel(fwd_rs_sel4), .fwd_rt_sel(fwd_rt_sel4), .mdu_busy(mdu_busy4), .stall_cnt(stall_cnt4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: an operand stalls if any matching producer is not ready in time; the
  // forwarded stage is the nearest one whose value is ready (farthest overwritten last).
  task automatic model_hazard(input logic [4:0] r, input logic [TW-1:0] tuse,
                              output bit st, output int sel);
    st = 0;
    sel = 0;
    for (int k = NPROD - 1; k >= 0; k--) begin
      if (r != 0 && td[k] == r) begin
        if (int'(tuse) < int'(tn[k])) st = 1;
        if (tn[k] == 0) sel = k + 1;
      end
    end
  endtask

  task automatic clear_inputs();
    d_rs = 0; d_rt = 0; d_rs_tuse = 0; d_rt_tuse = 0; d_mdu_use = 0;
    e_mdu_start = 0; e_mdu_div = 0;
    for (int k = 0; k < NPROD; k++) begin td[k] = 0; tn[k] = 0; end
  endtask

  // One clock cycle: compare every output with the model, then advance model and DUT.
  task automatic tick(input string tag, input int exp_stall);
    bit st_rs, st_rt, m_busy, m_st;
    int sel_rs, sel_rt;
    #2;
    model_hazard(d_rs, d_rs_tuse, st_rs, sel_rs);
    model_hazard(d_rt, d_rt_tuse, st_rt, sel_rt);
    m_busy = (cyc < busy_until);
    m_st = st_rs | st_rt | (d_mdu_use & (e_mdu_start | m_busy));
    chk({tag, " stall"}, 64'(stall), 64'(m_st));
    chk({tag, " e_bubble"}, 64'(e_bubble), 64'(m_st));
    chk({tag, " fwd_rs"}, 64'(fwd_rs_sel), 64'(sel_rs));
    chk({tag, " fwd_rt"}, 64'(fwd_rt_sel), 64'(sel_rt));
    chk({tag, " mdu_busy"}, 64'(mdu_busy), 64'(m_busy));
    chk({tag, " stall_cnt"}, 64'(stall_cnt), 64'(m_cnt32));
    chk({tag, " stall_cnt4"}, 64'(stall_cnt4), 64'(m_cnt4));
    chk({tag, " stall4"}, 64'(stall4), 64'(m_st));
    if (exp_stall >= 0) chk({tag, " stall_expected"}, 64'(stall), 64'(exp_stall));
    if (!reset) begin
      busy_until = 0;
      m_cnt32 = 0;
      m_cnt4 = 0;
    end else begin
      if (e_mdu_start) busy_until = cyc + 1 + (e_mdu_div ? 10 : 5);
      if (m_st) begin
        if (m_cnt32 < 64'hFFFF_FFFF) m_cnt32++;
        if (m_cnt4 < 15) m_cnt4++;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    @(posedge clk);
    #1;

    // Reset held two cycles, then idle after release
    tick("t1_rst_a", 0);
    tick("t1_rst_b", 0);
    chk("t1 busy_after_rst", 64'(mdu_busy), 64'(0));
    chk("t1 cnt_after_rst", 64'(stall_cnt), 64'(0));
    reset = 1'b1;
    tick("t1_idle_a", 0);
    tick("t1_idle_b", 0);
    chk("t1 cnt_idle", 64'(stall_cnt), 64'(0));

    // Load-use: lw to $8 in E, add in D needs $8 next cycle
    td[0] = 8; tn[0] = 2; d_rs = 8; d_rs_tuse = 1;
    tick("t2_loaduse", 1);
    td[0] = 3; tn[0] = 1; td[1] = 8; tn[1] = 1;
    tick("t2_wait", 0);
    chk("t2 fwd_none", 64'(fwd_rs_sel), 64'(0));
    tn[1] = 0;
    tick("t2_ready", 0);
    chk("t2 fwd_stage1", 64'(fwd_rs_sel), 64'(2));

    // Both stages write $5 and are ready: nearest wins; $zero never matches
    clear_inputs();
    td[0] = 5; td[1] = 5; d_rt = 5;
    tick("t3_nearest", 0);
    chk("t3 fwd_rt_stage0", 64'(fwd_rt_sel), 64'(1));
    clear_inputs();
    d_rs = 0; td[0] = 0; tn[0] = 3; td[1] = 0; tn[1] = 0;
    tick("t3_zero", 0);
    chk("t3 fwd_rs_zero", 64'(fwd_rs_sel), 64'(0));

    // Divide start, then mflo in D: stalled for ten cycles, free on the eleventh
    clear_inputs();
    e_mdu_start = 1; e_mdu_div = 1;
    tick("t4_start", 0);
    e_mdu_start = 0; e_mdu_div = 0;
    for (int i = 1; i <= 10; i++) begin
      d_mdu_use = (i != 5);
      tick($sformatf("t4_win%0d", i), (i != 5) ? 1 : 0);
    end
    d_mdu_use = 1;
    tick("t4_free", 0);

    // Mult then div two cycles later restarts the countdown; reset mid-divide clears it
    clear_inputs();
    e_mdu_start = 1;
    tick("t5_mult", 0);
    e_mdu_start = 0;
    tick("t5_gap_a", 0);
    tick("t5_gap_b", 0);
    e_mdu_start = 1; e_mdu_div = 1;
    tick("t5_div", 0);
    e_mdu_start = 0; e_mdu_div = 0;
    for (int i = 1; i <= 6; i++) tick($sformatf("t5_busy%0d", i), 0);
    chk("t5 busy_before_rst", 64'(mdu_busy), 64'(1));
    reset = 1'b0;
    tick("t5_rst", 0);
    chk("t5 busy_drop", 64'(mdu_busy), 64'(0));
    reset = 1'b1;

    // Long stall: 4-bit counter saturates at 15, 32-bit one keeps counting
    clear_inputs();
    td[0] = 9; tn[0] = 3; d_rs = 9; d_rs_tuse = 0;
    for (int i = 0; i < 20; i++) tick($sformatf("t6_hold%0d", i), 1);
    chk("t6 cnt4_sat", 64'(stall_cnt4), 64'(15));
    chk("t6 cnt32", 64'(stall_cnt), 64'(20));

    // Randomized traffic, small register space to provoke collisions
    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(0, 39) != 0);
      d_rs        = 5'($urandom_range(0, 7));
      d_rt        = 5'($urandom_range(0, 7));
      d_rs_tuse   = 3'($urandom_range(0, 7));
      d_rt_tuse   = 3'($urandom_range(0, 7));
      d_mdu_use   = 1'($urandom_range(0, 1));
      e_mdu_start = ($urandom_range(0, 7) == 0);
      e_mdu_div   = 1'($urandom_range(0, 1));
      for (int k = 0; k < NPROD; k++) begin
        td[k] = 5'($urandom_range(0, 7));
        tn[k] = 3'($urandom_range(0, 3));
      end
      tick($sformatf("rnd%0d", i), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
